// File: rtl/sr_bank_sched_pkg.sv
// Shared encodings for the SR bank sequencer: requester op codes,
// per-bit {s,r} drive codes and the sequencer state set.
package sr_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_ILL = 2'b00,
    OP_SET = 2'b01,
    OP_CLR = 2'b10,
    OP_TGL = 2'b11
  } op_e;

  // {s,r} codes; 2'b00 is the undefined SR input and is never driven
  localparam logic [1:0] SR_SET  = 2'b10;
  localparam logic [1:0] SR_CLR  = 2'b01;
  localparam logic [1:0] SR_HOLD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_APPLY,
    ST_VERIFY,
    ST_CLEAR
  } state_e;

endpackage

// File: rtl/sr_bank_sched_if.sv
// Requester-side handshake bundle: per-requester request level, op and
// target index, returned one-hot ack with its error flag.
interface sr_bank_sched_if #(
  parameter int NREQ  = 4,
  parameter int NBITS = 8
);
  localparam int IDXW = $clog2(NBITS);

  logic [NREQ-1:0]      req;
  logic [2*NREQ-1:0]    req_op;
  logic [IDXW*NREQ-1:0] req_idx;
  logic [NREQ-1:0]      ack;
  logic                 ack_err;

  modport master (output req, req_op, req_idx, input ack, ack_err);
  modport slave  (input req, req_op, req_idx, output ack, ack_err);
endinterface

// File: rtl/sr_bank_sched_rr_arbiter.sv
// Combinational round-robin pick: first active request at or after ptr,
// wrapping modulo NREQ. Returns one-hot grant plus the winner index.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] win,
  output logic                    any
);
  localparam int PTRW = $clog2(NREQ);

  // scan requesters starting at the pointer, first hit wins
  always_comb begin
    int unsigned c;
    c   = 0;
    gnt = '0;
    win = '0;
    any = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      c = (32'(ptr) + i) % NREQ;
      if (!any && req[c]) begin
        any    = 1'b1;
        gnt[c] = 1'b1;
        win    = PTRW'(c);
      end
    end
  end

endmodule

// File: rtl/sr_bank_sched.sv
// Sequencer for a shared SR flop bank: arbitrates requesters round-robin,
// drives a one-cycle {s,r} code on the target bit, verifies q read-back
// and acknowledges. All bits not being written sit at the HOLD code.
module sr_bank_sched
  import sr_ctrl_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int NBITS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_all,
  sr_bank_sched_if.slave   bus,
  output logic [NBITS-1:0] s_out,
  output logic [NBITS-1:0] r_out,
  output logic             bank_rstn,
  input  logic [NBITS-1:0] q_in,
  output logic             busy
);
  localparam int IDXW = $clog2(NBITS);
  localparam int PTRW = $clog2(NREQ);

  state_e            state;
  logic [PTRW-1:0]   ptr;
  logic [PTRW-1:0]   win_q;
  logic [NREQ-1:0]   gnt_q;
  logic [IDXW-1:0]   idx_q;
  logic              exp_q;
  logic              err_q;

  logic [NREQ-1:0]   gnt;
  logic [PTRW-1:0]   win;
  logic              any;
  op_e               win_op;
  logic [IDXW-1:0]   win_idx;
  logic              idx_bad;
  logic              cur_q;
  logic              rb;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req (bus.req),
    .ptr (ptr),
    .gnt (gnt),
    .win (win),
    .any (any)
  );

  // decode the winning requester's op/idx and the current bank value
  always_comb begin
    win_op  = op_e'(bus.req_op[32'(win)*2 +: 2]);
    win_idx = bus.req_idx[32'(win)*IDXW +: IDXW];
    idx_bad = (32'(win_idx) >= NBITS);
    cur_q   = idx_bad ? 1'b0 : q_in[win_idx];
    rb      = (32'(idx_q) < NBITS) ? q_in[idx_q] : 1'b0;
  end

  // sequencer FSM with registered bank codes and ack
  // The APPLY code is registered at the IDLE->APPLY edge, so toggle
  // direction comes from q_in on that edge; the bank is in HOLD through
  // IDLE, so this is the same value q_in shows during APPLY.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      win_q     <= '0;
      gnt_q     <= '0;
      idx_q     <= '0;
      exp_q     <= 1'b0;
      err_q     <= 1'b0;
      bus.ack   <= '0;
      s_out     <= '1;
      r_out     <= '1;
      bank_rstn <= 1'b0;
    end else begin
      bank_rstn <= 1'b1;
      s_out     <= '1;
      r_out     <= '1;
      bus.ack   <= '0;
      case (state)
        ST_IDLE: begin
          if (clr_all) begin
            s_out <= '0;
            state <= ST_CLEAR;
          end else if (any) begin
            gnt_q <= gnt;
            win_q <= win;
            idx_q <= win_idx;
            err_q <= 1'b0;
            if (win_op == OP_ILL || idx_bad) begin
              err_q   <= 1'b1;
              bus.ack <= gnt;
              state   <= ST_VERIFY;
            end else begin
              state <= ST_APPLY;
              case (win_op)
                OP_SET: begin
                  {s_out[win_idx], r_out[win_idx]} <= SR_SET;
                  exp_q <= 1'b1;
                end
                OP_CLR: begin
                  {s_out[win_idx], r_out[win_idx]} <= SR_CLR;
                  exp_q <= 1'b0;
                end
                OP_TGL: begin
                  {s_out[win_idx], r_out[win_idx]} <= cur_q ? SR_CLR : SR_SET;
                  exp_q <= ~cur_q;
                end
                default: begin
                  {s_out[win_idx], r_out[win_idx]} <= SR_HOLD;
                end
              endcase
            end
          end
        end
        ST_APPLY: begin
          bus.ack <= gnt_q;
          state   <= ST_VERIFY;
        end
        ST_VERIFY: begin
          ptr   <= (win_q == PTRW'(NREQ-1)) ? '0 : win_q + PTRW'(1);
          state <= ST_IDLE;
        end
        ST_CLEAR: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // read-back compare is evaluated against the bank value seen during VERIFY
  assign bus.ack_err = (state == ST_VERIFY) && (err_q || (rb != exp_q));
  assign busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_sr_bank_sched.sv
// Self-checking bench for sr_bank_sched: behavioural SR bank model,
// ack scoreboard, table-driven single ops and hand-written corner sequences.
module tb_sr_bank_sched;
  import sr_ctrl_pkg::*;

  localparam int NREQ  = 4;
  localparam int NBITS = 8;
  localparam int IDXW  = 3;
  localparam int NB2   = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr_all = 1'b0;
  always #5 clk = ~clk;

  sr_bank_sched_if #(.NREQ(NREQ), .NBITS(NBITS)) bus ();
  sr_bank_sched_if #(.NREQ(NREQ), .NBITS(NB2))   bus2 ();

  logic [NBITS-1:0] s_out, r_out;
  logic [NBITS-1:0] q = '0;
  logic             bank_rstn, busy;
  logic [NB2-1:0]   s2, r2;
  logic [NB2-1:0]   q2;
  logic             bank_rstn2, busy2;
  assign q2 = '1;

  sr_bank_sched #(.NREQ(NREQ), .NBITS(NBITS)) dut (
    .clk(clk), .rst(rst), .clr_all(clr_all), .bus(bus),
    .s_out(s_out), .r_out(r_out), .bank_rstn(bank_rstn),
    .q_in(q), .busy(busy)
  );

  // second instance with a non-power-of-two bank so idx>=NBITS is encodable
  sr_bank_sched #(.NREQ(NREQ), .NBITS(NB2)) dut2 (
    .clk(clk), .rst(rst), .clr_all(1'b0), .bus(bus2),
    .s_out(s2), .r_out(r2), .bank_rstn(bank_rstn2),
    .q_in(q2), .busy(busy2)
  );

  // SR flop bank model
  always @(posedge clk) begin
    if (bank_rstn === 1'b0) q <= '0;
    else
      for (int i = 0; i < NBITS; i++) begin
        if (s_out[i] === 1'b1 && r_out[i] === 1'b0) q[i] <= 1'b1;
        else if (s_out[i] === 1'b0 && r_out[i] === 1'b1) q[i] <= 1'b0;
      end
  end

  int vectors = 0;
  int miscompares = 0;
  bit started = 1'b0;

  typedef struct packed {logic [3:0] ack; logic err;} exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input int id, input logic [1:0] op, input logic [IDXW-1:0] idx);
    bus.req[id] = 1'b1;
    bus.req_op[2*id +: 2] = op;
    bus.req_idx[IDXW*id +: IDXW] = idx;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  // scoreboard: every ack must match the next queued expectation
  always @(negedge clk) begin
    if (started && rst === 1'b0 && bus.ack !== '0) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL ack_unexpected: got %b expected none at %0t", bus.ack, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_ack", 32'(bus.ack), 32'(e.ack));
        chk("sb_err", 32'(bus.ack_err), 32'(e.err));
      end
    end
  end

  // the forbidden {s,r}=00 code must never appear on either bank
  always @(negedge clk) begin
    if (started) begin
      if ((s_out | r_out) !== '1) begin
        miscompares++;
        $display("FAIL sr00: s=%h r=%h at %0t", s_out, r_out, $time);
      end
      if ((s2 | r2) !== '1) begin
        miscompares++;
        $display("FAIL sr00_b: s=%h r=%h at %0t", s2, r2, $time);
      end
    end
  end

  typedef struct {
    int         id;
    logic [1:0] op;
    logic [2:0] idx;
    logic [7:0] s;
    logic [7:0] r;
    logic       err;
    logic       qb;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    int seen;
    int n;
    int order[5];

    tbl[0] = '{0, 2'b01, 3'd3, 8'hFF, 8'hF7, 1'b0, 1'b1};
    tbl[1] = '{2, 2'b01, 3'd5, 8'hFF, 8'hDF, 1'b0, 1'b1};
    tbl[2] = '{2, 2'b11, 3'd5, 8'hDF, 8'hFF, 1'b0, 1'b0};
    tbl[3] = '{1, 2'b11, 3'd0, 8'hFF, 8'hFE, 1'b0, 1'b1};
    tbl[4] = '{3, 2'b10, 3'd3, 8'hF7, 8'hFF, 1'b0, 1'b0};
    tbl[5] = '{1, 2'b00, 3'd2, 8'hFF, 8'hFF, 1'b1, 1'b0};
    tbl[6] = '{0, 2'b10, 3'd7, 8'h7F, 8'hFF, 1'b0, 1'b0};
    tbl[7] = '{3, 2'b01, 3'd7, 8'hFF, 8'h7F, 1'b0, 1'b1};
    order = '{0, 1, 2, 3, 0};

    bus.req = '0;  bus.req_op = '0;  bus.req_idx = '0;
    bus2.req = '0; bus2.req_op = '0; bus2.req_idx = '0;

    // reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_s", 32'(s_out), 32'hFF);
    chk("rst_r", 32'(r_out), 32'hFF);
    chk("rst_bank_rstn", 32'(bank_rstn), 32'd0);
    chk("rst_ack", 32'(bus.ack), 32'd0);
    chk("rst_ack_err", 32'(bus.ack_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    started = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_release_bank_rstn", 32'(bank_rstn), 32'd1);

    // table of single operations
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      set_req(tbl[k].id, tbl[k].op, tbl[k].idx);
      sb.push_back('{ack: 4'b0001 << tbl[k].id, err: tbl[k].err});
      @(posedge clk);
      #1 bus.req[tbl[k].id] = 1'b0;
      @(negedge clk);
      chk("vec_s", 32'(s_out), 32'(tbl[k].s));
      chk("vec_r", 32'(r_out), 32'(tbl[k].r));
      if (tbl[k].op == 2'b00) begin
        chk("vec_ack_lat_err", 32'(bus.ack), 32'(4'b0001 << tbl[k].id));
      end else begin
        @(negedge clk);
        chk("vec_ack_lat", 32'(bus.ack), 32'(4'b0001 << tbl[k].id));
      end
      wait_idle();
      chk("vec_q", 32'(q[tbl[k].idx]), 32'(tbl[k].qb));
    end

    // out-of-range index on the 6-bit bank
    @(negedge clk);
    bus2.req[1] = 1'b1;
    bus2.req_op[3:2] = 2'b01;
    bus2.req_idx[5:3] = 3'd6;
    @(posedge clk);
    #1 bus2.req = '0;
    @(negedge clk);
    chk("badidx_ack", 32'(bus2.ack), 32'b0010);
    chk("badidx_err", 32'(bus2.ack_err), 32'd1);
    chk("badidx_s", 32'(s2), 32'h3F);
    chk("badidx_r", 32'(r2), 32'h3F);
    @(negedge clk);
    chk("badidx_done", 32'(busy2), 32'd0);

    // all requesters held: round-robin 0,1,2,3,0
    @(negedge clk);
    for (int id = 0; id < 4; id++) set_req(id, 2'b01, IDXW'(4 + id));
    for (int k = 0; k < 5; k++) sb.push_back('{ack: 4'b0001 << order[k], err: 1'b0});
    seen = 0;
    n = 0;
    while (seen < 5 && n < 60) begin
      @(negedge clk);
      n++;
      if (bus.ack !== '0) begin
        seen++;
        if (seen == 5) bus.req = '0;
      end
    end
    bus.req = '0;
    chk("rr_ack_count", 32'(seen), 32'd5);
    wait_idle();

    // clr_all wins over a simultaneous request
    @(negedge clk);
    clr_all = 1'b1;
    set_req(3, 2'b01, 3'd2);
    sb.push_back('{ack: 4'b1000, err: 1'b0});
    @(posedge clk);
    #1 clr_all = 1'b0;
    @(negedge clk);
    chk("clear_s", 32'(s_out), 32'h00);
    chk("clear_r", 32'(r_out), 32'hFF);
    chk("clear_ack", 32'(bus.ack), 32'd0);
    @(negedge clk);
    chk("clear_idle_ack", 32'(bus.ack), 32'd0);
    @(negedge clk);
    chk("clear_apply_r", 32'(r_out), 32'hFB);
    @(negedge clk);
    chk("clear_then_ack", 32'(bus.ack), 32'b1000);
    bus.req = '0;
    wait_idle();
    chk("clear_q", 32'(q), 32'h04);

    // reset in the middle of APPLY drops the op
    @(negedge clk);
    set_req(0, 2'b01, 3'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("abort_apply_r", 32'(r_out), 32'hFD);
    rst = 1'b1;
    bus.req = '0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_s", 32'(s_out), 32'hFF);
    chk("abort_r", 32'(r_out), 32'hFF);
    chk("abort_ack", 32'(bus.ack), 32'd0);
    chk("abort_bank_rstn", 32'(bank_rstn), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("abort_no_ack", 32'(bus.ack), 32'd0);
    end

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
